// File: rtl/dcache_mem_bridge_pkg.sv
// dcache_mem_bridge_pkg: transfer-type codes and line geometry shared by the cache memory-side logic
package dcache_mem_bridge_pkg;
    localparam logic [2:0] TYPE_BYTE = 3'b000;
    localparam logic [2:0] TYPE_HALF = 3'b001;
    localparam logic [2:0] TYPE_WORD = 3'b010;
    localparam logic [2:0] TYPE_LINE = 3'b100;
    localparam int LINE_WORDS_DEF = 4;
endpackage

// File: rtl/dcache_mem_bridge.sv
// dcache_mem_bridge: serialises dcache read/write requests into single-word req/gnt memory beats
module dcache_mem_bridge
    import dcache_mem_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rd_req,
    input  logic [2:0]                       rd_type,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic                             rd_rdy,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    output logic                             rd_last,
    input  logic                             wr_req,
    input  logic [2:0]                       wr_type,
    input  logic [3:0]                       wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH*LINE_WORDS-1:0] wr_data,
    output logic                             wr_rdy,
    output logic                             mem_req,
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [3:0]                       mem_wstrb,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic                             mem_gnt,
    input  logic                             mem_rvalid,
    input  logic [DATA_WIDTH-1:0]            mem_rdata
);
    localparam int CW = LINE_WORDS > 1 ? $clog2(LINE_WORDS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_WORDS * DATA_WIDTH / 8 - 1);

    typedef enum logic [1:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT} state_t;

    state_t                        state, state_nxt;
    logic                          idle_q, line_q;
    logic [CW-1:0]                 cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0]         base_q, addr_nxt, wr_base, rd_base;
    logic [DATA_WIDTH*LINE_WORDS-1:0] wdata_q;
    logic                          wr_acc, rd_acc, wr_line, rd_line, last;

    // idle_q mirrors state==IDLE but is held low during reset so ready rises only after release
    assign wr_rdy   = idle_q;
    assign rd_rdy   = idle_q && !wr_req;
    assign wr_acc   = wr_req && wr_rdy;
    assign rd_acc   = rd_req && rd_rdy;
    assign wr_line  = wr_type == TYPE_LINE;
    assign rd_line  = rd_type == TYPE_LINE;
    assign wr_base  = wr_line ? (wr_addr & LINE_MASK) : wr_addr;
    assign rd_base  = rd_line ? (rd_addr & LINE_MASK) : rd_addr;
    assign last     = !line_q || cnt == CW'(LINE_WORDS - 1);
    assign cnt_nxt  = cnt + CW'(1);
    assign addr_nxt = base_q + (ADDR_WIDTH'(cnt_nxt) << 2);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = wr_acc ? WR_ISSUE : rd_acc ? RD_ISSUE : IDLE;
            WR_ISSUE: state_nxt = (mem_gnt && last) ? IDLE : WR_ISSUE;
            RD_ISSUE: state_nxt = mem_gnt ? RD_WAIT : RD_ISSUE;
            RD_WAIT:  state_nxt = !mem_rvalid ? RD_WAIT : last ? IDLE : RD_ISSUE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idle_q    <= 1'b0;
            line_q    <= 1'b0;
            cnt       <= '0;
            base_q    <= '0;
            wdata_q   <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wstrb <= '0;
            mem_wdata <= '0;
        end else begin
            state    <= state_nxt;
            idle_q   <= state_nxt == IDLE;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (wr_acc) begin
                line_q    <= wr_line;
                cnt       <= '0;
                base_q    <= wr_base;
                wdata_q   <= wr_data;
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= wr_base;
                mem_wstrb <= wr_line ? 4'hF : wr_en;
                mem_wdata <= wr_data[DATA_WIDTH-1:0];
            end else if (rd_acc) begin
                line_q    <= rd_line;
                cnt       <= '0;
                base_q    <= rd_base;
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= rd_base;
                mem_wstrb <= '0;
                mem_wdata <= '0;
            end else if (state == WR_ISSUE && mem_gnt) begin
                mem_req <= !last;
                if (!last) begin
                    cnt       <= cnt_nxt;
                    mem_addr  <= addr_nxt;
                    mem_wdata <= wdata_q[DATA_WIDTH*cnt_nxt +: DATA_WIDTH];
                end
            end else if (state == RD_ISSUE && mem_gnt) begin
                mem_req <= 1'b0;
            end else if (state == RD_WAIT && mem_rvalid) begin
                rd_valid <= 1'b1;
                rd_data  <= mem_rdata;
                rd_last  <= last;
                mem_req  <= !last;
                if (!last) begin
                    cnt      <= cnt_nxt;
                    mem_addr <= addr_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_dcache_mem_bridge.sv
// tb_dcache_mem_bridge: table vectors, hand sequences and random traffic against a transaction-level model
module tb_dcache_mem_bridge;
    typedef struct {
        bit           wr;
        logic [2:0]   typ;
        logic [31:0]  addr;
        logic [3:0]   en;
        logic [127:0] data;
    } req_t;

    typedef struct {
        req_t        r;
        int          n;
        logic [31:0] a0;
        logic [3:0]  s0;
        logic [31:0] w0;
        logic [31:0] d0;
        int          first;
        int          done;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        int          scyc;
        int          gcyc;
    } beat_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          cyc;
    } ret_t;

    logic         clk = 1'b0, rst = 1'b1;
    logic         rd_req = 1'b0, wr_req = 1'b0;
    logic [2:0]   rd_type = '0, wr_type = '0;
    logic [31:0]  rd_addr = '0, wr_addr = '0;
    logic [3:0]   wr_en = '0;
    logic [127:0] wr_data = '0;
    logic         rd_rdy, rd_valid, rd_last, wr_rdy;
    logic [31:0]  rd_data;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr, mem_wdata;
    logic [3:0]   mem_wstrb;
    logic         mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0]  mem_rdata = '0;

    int n_chk = 0, n_fail = 0, cyc = 0;
    bit gnt_rand = 0, rv_rand = 0;
    int stall_q[$];
    beat_t beats[$];
    ret_t rets[$];
    logic [31:0] pre [logic [31:0]];

    dcache_mem_bridge dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .wr_req(wr_req), .wr_type(wr_type), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_rdy(wr_rdy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        return pre.exists(k) ? pre[k] : (k ^ 32'h9E37_79B9);
    endfunction

    // Memory model: grants after a per-beat stall, answers reads after an optional delay
    initial begin
        beat_t cur;
        bit in_beat, pend;
        int stall, rdly;
        logic [31:0] raddr;
        in_beat = 0; pend = 0; stall = 0; rdly = 0; raddr = '0;
        cur = '{1'b0, 32'h0, 4'h0, 32'h0, 0, 0};
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                mem_gnt = 0; mem_rvalid = 0; in_beat = 0; pend = 0;
                continue;
            end
            if (in_beat && mem_gnt) begin
                cur.gcyc = cyc - 1;
                beats.push_back(cur);
                if (!cur.we) begin
                    pend = 1; raddr = cur.addr; rdly = rv_rand ? int'($urandom_range(0, 3)) : 0;
                end
                in_beat = 0;
            end
            mem_rvalid = 0;
            if (pend) begin
                if (rdly == 0) begin mem_rvalid = 1; mem_rdata = mem_word(raddr); pend = 0; end
                else rdly--;
            end
            if (mem_req && !in_beat) begin
                in_beat = 1;
                cur = '{mem_we, mem_addr, mem_wstrb, mem_wdata, cyc, 0};
                stall = stall_q.size() > 0 ? stall_q.pop_front() : (gnt_rand ? int'($urandom_range(0, 3)) : 0);
            end else if (in_beat) begin
                chk("stall_addr", mem_addr, cur.addr);
                chk("stall_ctrl", {26'h0, mem_req, mem_we, mem_wstrb}, {26'h0, 1'b1, cur.we, cur.strb});
                chk("stall_wdata", mem_wdata, cur.wdata);
            end
            mem_gnt = in_beat && stall == 0;
            if (in_beat && stall > 0) stall--;
        end
    end

    initial forever begin
        @(posedge clk); #2;
        if (!rst && rd_valid) rets.push_back('{rd_data, rd_last, cyc});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic issue(input req_t r, output int acc);
        int w;
        w = 0;
        beats.delete();
        rets.delete();
        @(posedge clk); #1;
        if (r.wr) begin
            wr_req = 1; wr_type = r.typ; wr_addr = r.addr; wr_en = r.en; wr_data = r.data;
        end else begin
            rd_req = 1; rd_type = r.typ; rd_addr = r.addr;
        end
        #2;
        while (!(r.wr ? wr_rdy : rd_rdy) && w < 100) begin @(posedge clk); #3; w++; end
        if (w >= 100) fail("accept");
        acc = cyc;
        @(posedge clk); #1;
        wr_req = 0; rd_req = 0;
    endtask

    task automatic wait_idle(output int done);
        int w;
        w = 0;
        #2;
        while (!wr_rdy && w < 500) begin @(posedge clk); #3; w++; end
        if (w >= 500) fail("idle");
        done = cyc;
    endtask

    // Transaction-level expectation: beat count, addresses, strobes, data and returns
    task automatic verify(input req_t r);
        bit line;
        int n;
        logic [31:0] base;
        line = r.typ == 3'b100;
        n = line ? 4 : 1;
        base = line ? {r.addr[31:4], 4'h0} : r.addr;
        chk("beat_count", beats.size(), n);
        chk("ret_count", rets.size(), r.wr ? 0 : n);
        for (int i = 0; i < n && i < beats.size(); i++) begin
            chk("beat_addr", beats[i].addr, base + 32'(4 * i));
            chk("beat_we", {31'h0, beats[i].we}, {31'h0, r.wr});
            chk("beat_strb", {28'h0, beats[i].strb}, {28'h0, r.wr ? (line ? 4'hF : r.en) : 4'h0});
            if (r.wr) chk("beat_wdata", beats[i].wdata, line ? r.data[32*i +: 32] : r.data[31:0]);
        end
        for (int i = 0; i < n && i < rets.size() && !r.wr; i++) begin
            chk("rd_data", rets[i].data, mem_word(base + 32'(4 * i)));
            chk("rd_last", {31'h0, rets[i].last}, {31'h0, i == n - 1});
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, {24'h0, rd_rdy, wr_rdy, rd_valid, rd_last, mem_req, mem_we, mem_wstrb[1:0]}, 32'h0);
        chk({tag, "_strb"}, {28'h0, mem_wstrb}, 32'h0);
        chk({tag, "_rd_data"}, rd_data, 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    initial begin
        vec_t vt[7];
        req_t r;
        int acc, done, w;
        pre[32'h1004] = 32'hDEAD_BEEF;
        pre[32'h2000] = 32'h0A0A_0A0A;
        pre[32'h5000] = 32'hCAFE_F00D;
        pre[32'h8008] = 32'h1357_9BDF;
        vt[0] = '{'{0, 3'b010, 32'h1004, 4'h0, 128'h0}, 1, 32'h1004, 4'h0, 32'h0, 32'hDEAD_BEEF, 3, 3};
        vt[1] = '{'{0, 3'b100, 32'h200C, 4'h0, 128'h0}, 4, 32'h2000, 4'h0, 32'h0, 32'h0A0A_0A0A, 3, 9};
        vt[2] = '{'{1, 3'b000, 32'h4003, 4'h8, 128'hAB00_0000}, 1, 32'h4003, 4'h8, 32'hAB00_0000, 32'h0, -1, 2};
        vt[3] = '{'{0, 3'b001, 32'h5002, 4'h0, 128'h0}, 1, 32'h5002, 4'h0, 32'h0, 32'hCAFE_F00D, 3, 3};
        vt[4] = '{'{1, 3'b011, 32'h6001, 4'h3, 128'h5566_7788}, 1, 32'h6001, 4'h3, 32'h5566_7788, 32'h0, -1, 2};
        vt[5] = '{'{1, 3'b100, 32'h700F, 4'h0, 128'h44444444_33333333_22222222_11111111},
                  4, 32'h7000, 4'hF, 32'h1111_1111, 32'h0, -1, 5};
        vt[6] = '{'{0, 3'b111, 32'h8008, 4'h0, 128'h0}, 1, 32'h8008, 4'h0, 32'h0, 32'h1357_9BDF, 3, 3};

        @(posedge clk); #3;
        chk_zero("reset");
        @(posedge clk); #1;
        rst = 0;
        #2;
        chk("rdy_in_release_cycle", {30'h0, rd_rdy, wr_rdy}, 32'h0);
        @(posedge clk); #3;
        chk("rdy_after_release", {30'h0, rd_rdy, wr_rdy}, 32'h3);

        for (int v = 0; v < 7; v++) begin
            issue(vt[v].r, acc);
            wait_idle(done);
            verify(vt[v].r);
            chk("vec_beats", beats.size(), vt[v].n);
            if (beats.size() > 0) begin
                chk("vec_addr0", beats[0].addr, vt[v].a0);
                chk("vec_strb0", {28'h0, beats[0].strb}, {28'h0, vt[v].s0});
                chk("vec_first_req", beats[0].scyc - acc, 1);
                if (vt[v].r.wr) chk("vec_wdata0", beats[0].wdata, vt[v].w0);
            end
            if (!vt[v].r.wr && rets.size() > 0) chk("vec_rdata0", rets[0].data, vt[v].d0);
            for (int i = 0; i < rets.size(); i++) chk("vec_rv_cycle", rets[i].cyc - acc, vt[v].first + 2 * i);
            chk("vec_done", done - acc, vt[v].done);
        end

        // Line write with a 3-cycle grant stall on the second beat
        stall_q.push_back(0);
        stall_q.push_back(3);
        r = '{1, 3'b100, 32'h3000, 4'h0, 128'h44444444_33333333_22222222_11111111};
        issue(r, acc);
        wait_idle(done);
        verify(r);
        if (beats.size() == 4) chk("stall_beat1_gnt", beats[1].gcyc - acc, 5);
        chk("stall_done", done - acc, 8);

        // Simultaneous write and read: write drains before the read's first beat
        beats.delete();
        rets.delete();
        @(posedge clk); #1;
        wr_req = 1; wr_type = 3'b010; wr_addr = 32'hA000; wr_en = 4'hF; wr_data = 128'h1234_5678;
        rd_req = 1; rd_type = 3'b010; rd_addr = 32'hB000;
        #2;
        chk("both_rd_rdy", {31'h0, rd_rdy}, 32'h0);
        chk("both_wr_rdy", {31'h0, wr_rdy}, 32'h1);
        @(posedge clk); #1;
        wr_req = 0;
        #2;
        w = 0;
        while (!rd_rdy && w < 100) begin @(posedge clk); #3; w++; end
        if (w >= 100) fail("both_read_accept");
        @(posedge clk); #1;
        rd_req = 0;
        wait_idle(done);
        chk("both_beats", beats.size(), 2);
        chk("both_rets", rets.size(), 1);
        if (beats.size() == 2) begin
            chk("both_first_is_write", {31'h0, beats[0].we}, 32'h1);
            chk("both_write_addr", beats[0].addr, 32'hA000);
            chk("both_read_addr", beats[1].addr, 32'hB000);
            chk("both_order", {31'h0, beats[1].scyc > beats[0].gcyc}, 32'h1);
        end
        if (rets.size() == 1) chk("both_rd_data", rets[0].data, mem_word(32'hB000));

        // Reset in the middle of a line read, then a normal word read
        r = '{0, 3'b100, 32'h9000, 4'h0, 128'h0};
        issue(r, acc);
        w = 0;
        while (rets.size() < 1 && w < 50) begin @(posedge clk); #3; w++; end
        if (w >= 50) fail("rst_first_beat");
        @(posedge clk); #1;
        rst = 1;
        #2;
        chk_zero("midrst");
        @(posedge clk); #1;
        rst = 0;
        r = '{0, 3'b010, 32'h1004, 4'h0, 128'h0};
        issue(r, acc);
        wait_idle(done);
        verify(r);
        if (rets.size() == 1) chk("post_rst_data", rets[0].data, 32'hDEAD_BEEF);

        // Random traffic with random grant stalls and read latency
        gnt_rand = 1;
        rv_rand = 1;
        for (int k = 0; k < 40; k++) begin
            r.wr = 1'($urandom_range(0, 1));
            r.typ = 3'($urandom_range(0, 7));
            r.addr = $urandom;
            r.en = 4'($urandom);
            r.data = {$urandom, $urandom, $urandom, $urandom};
            issue(r, acc);
            wait_idle(done);
            verify(r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
